lane_arbiter: RTL



---
 rtl/lane_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lane_arbiter.sv
// lane_arbiter
// Shares one child datapath among four requesters. A request is sampled only
// while the block is IDLE; the winner is chosen round-robin, its operand is
// latched and driven on ch_in for one ISSUE cycle plus LATENCY WAIT cycles,
// then the child's result is registered and returned in a one-cycle RESP.
//
// Handshake: req[i] is a level; the block accepts requester i only at an IDLE
// edge where req[i]=1, signalled by the one-cycle grant[i] pulse that follows.
// The response is the one-cycle resp_valid pulse; there is no back-pressure,
// and resp_id/resp_data hold their values until the next response.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   req        request level per requester (bit i = requester i)
//   req_data   operands, requester i at req_data[4*i +: 4]
//   grant      one-hot acceptance pulse (ISSUE only)
//   ch_in      operand to the child datapath (0 in IDLE and RESP)
//   ch_out     result from the child datapath
//   resp_valid one-cycle response pulse
//   resp_id    requester index of the response
//   resp_data  registered child result
//   busy       high whenever the FSM is not IDLE
//   dbg_state  current FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module lane_arbiter #(
    parameter int LATENCY = 1  // child datapath latency, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] req_data,
    output logic [3:0]  grant,
    output logic [3:0]  ch_in,
    input  logic [3:0]  ch_out,
    output logic        resp_valid,
    output logic [1:0]  resp_id,
    output logic [3:0]  resp_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  idx;
    logic [3:0]  opnd;
    logic [3:0]  cnt;
    logic [1:0]  sel;

    assign dbg_state = state;

    // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap); the
    // first set request wins. sel is only used when |req is true.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt  = state;
        grant      = 4'b0000;
        ch_in      = 4'h0;
        resp_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) state_nxt = ISSUE;
            end
            ISSUE: begin
                grant     = 4'b0001 << idx;
                ch_in     = opnd;
                state_nxt = WAIT;
            end
            WAIT: begin
                ch_in = opnd;
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            idx       <= 2'd0;
            opnd      <= 4'h0;
            cnt       <= 4'd0;
            resp_id   <= 2'd0;
            resp_data <= 4'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx  <= sel;
                        opnd <= req_data[{sel, 2'b00} +: 4];
                    end
                end
                ISSUE: begin
                    cnt <= 4'(LATENCY - 1);
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_data <= ch_out;
                        // resp_id is registered here so it is valid during
                        // RESP and holds afterwards like resp_data.
                        resp_id   <= idx;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ptr <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
